// File: rtl/uart_pkg.sv
// Shared UART definitions: line-state encoding and baud timing derivation,
// common to the transmitter and receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int unsigned DATA_BITS       = 8;
    localparam int unsigned BIT_COUNT_WIDTH = 4;

    // Clock cycles per serial bit; the fractional remainder is dropped.
    function automatic int unsigned symbol_edge_time(input int unsigned clock_freq,
                                                     input int unsigned baud_rate);
        return clock_freq / baud_rate;
    endfunction

    function automatic int unsigned baud_count_width(input int unsigned edge_time);
        return (edge_time > 1) ? $clog2(edge_time) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: held at zero while cleared, pulses tick on the last
// cycle of every SYMBOL_EDGE_TIME-cycle bit period.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned SYMBOL_EDGE_TIME = 1085
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned COUNT_WIDTH = baud_count_width(SYMBOL_EDGE_TIME);
    localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(SYMBOL_EDGE_TIME - 1);

    logic [COUNT_WIDTH-1:0] count;

    assign tick = (count == LAST_COUNT);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a valid/ready byte input and a registered,
// idle-high serial line.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 125_000_000,
    parameter int unsigned BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic       serial_out
);

    localparam int unsigned SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam logic [BIT_COUNT_WIDTH-1:0] LAST_BIT = BIT_COUNT_WIDTH'(DATA_BITS - 1);

    uart_state_t                state, state_next;
    logic [DATA_BITS-1:0]       shift, shift_next;
    logic [BIT_COUNT_WIDTH-1:0] bit_count, bit_count_next;
    logic                       serial_next;
    logic                       handshake;
    logic                       baud_tick;
    logic                       line_idle;

    assign line_idle     = (state == IDLE);
    assign data_in_ready = line_idle && !reset;
    assign handshake     = data_in_valid && data_in_ready;

    uart_baud_tick #(
        .SYMBOL_EDGE_TIME(SYMBOL_EDGE_TIME)
    ) baud_tick_inst (
        .clk  (clk),
        .reset(reset),
        .clear(line_idle),
        .tick (baud_tick)
    );

    always_comb begin
        state_next     = state;
        shift_next     = shift;
        bit_count_next = bit_count;
        case (state)
            IDLE: begin
                if (handshake) begin
                    state_next     = START;
                    shift_next     = data_in;
                    bit_count_next = '0;
                end
            end
            START: begin
                if (baud_tick) state_next = DATA;
            end
            DATA: begin
                if (baud_tick) begin
                    shift_next = shift >> 1;
                    if (bit_count == LAST_BIT) begin
                        state_next     = STOP;
                        bit_count_next = '0;
                    end else begin
                        bit_count_next = bit_count + 1'b1;
                    end
                end
            end
            STOP: begin
                if (baud_tick) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // Line level is derived from where the frame will be next cycle so
        // serial_out can be a plain register with no extra latency.
        case (state_next)
            START:   serial_next = 1'b0;
            DATA:    serial_next = shift_next[0];
            default: serial_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            shift      <= '0;
            bit_count  <= '0;
            serial_out <= 1'b1;
        end else begin
            state      <= state_next;
            shift      <= shift_next;
            bit_count  <= bit_count_next;
            serial_out <= serial_next;
        end
    end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 125_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, serial line rate in bits/s.
REQ-003 SHALL have port clk  input  1  system clock; every register updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset; one clock, no other clock domain.
REQ-005 SHALL have port data_in  input  8  byte to transmit, sampled only on handshake.
REQ-006 SHALL have port data_in_valid  input  1  producer offers data_in.
REQ-007 SHALL have port data_in_ready  output  1  transmitter can accept a byte this cycle.
REQ-008 SHALL have port serial_out  output  1  UART line, idle high, 8N1 framing.

Function
REQ-009 SHALL derive SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE (integer division, 1085 at defaults) as the number of cycles per bit.
REQ-010 SHALL size the baud counter as clog2(SYMBOL_EDGE_TIME) bits and the bit counter as 4 bits, with no overflow in any state.
REQ-011 SHALL implement states IDLE, START, DATA, STOP.
REQ-012 SHALL drive data_in_ready = 1 only in IDLE, combinationally from state.
REQ-013 SHALL define the handshake as data_in_valid && data_in_ready at a rising edge; on that edge it latches data_in into an internal shift register and moves to START.
REQ-014 SHALL ignore data_in and data_in_valid in every state other than IDLE; changes to data_in after the handshake SHALL NOT affect the frame.
REQ-015 SHALL drive serial_out low starting the cycle after the handshake (one-cycle latency) for exactly SYMBOL_EDGE_TIME cycles (START).
REQ-016 SHALL in DATA drive the 8 latched bits LSB first, each for exactly SYMBOL_EDGE_TIME cycles.
REQ-017 SHALL in STOP drive serial_out high for exactly SYMBOL_EDGE_TIME cycles, then return to IDLE.
REQ-018 SHALL make a full frame occupy exactly 10 x SYMBOL_EDGE_TIME cycles with data_in_ready low, and reassert data_in_ready on the first cycle after STOP ends.
REQ-019 SHALL, when data_in_valid is held high, accept the next byte on the first IDLE cycle, giving back-to-back frames separated by one idle-high cycle.
REQ-020 SHALL hold serial_out high in IDLE whether or not data_in_valid is asserted.
REQ-021 SHALL register serial_out so it is glitch-free.

Reset
REQ-022 SHALL, on any cycle with reset high, force state to IDLE, clear the baud and bit counters, and drive serial_out = 1 on the next edge.
REQ-023 SHALL drive data_in_ready = 0 while reset is high and 1 on the first cycle after reset deasserts.
REQ-024 SHALL abort any in-progress frame on reset with no further bits; the aborted byte is discarded.
REQ-025 SHALL give reset priority over a simultaneous handshake, so no byte is accepted in a reset cycle.

Structure
REQ-026 SHALL place the state encoding (IDLE, START, DATA, STOP) and the SYMBOL_EDGE_TIME/counter-width derivation in the shared uart package/header used by the uart receiver.
REQ-027 SHALL use one sub-module, uart_baud_tick, which is a counter that clears on frame start and pulses on the last cycle of each bit period.
REQ-028 SHALL slot into the existing uart wrapper without changing the wrapper's ports.

Verification
REQ-029 SHALL cover: reset, then send 0x55 -> serial_out low 1085 cycles, then 1,0,1,0,1,0,1,0 at 1085 cycles each, then high 1085, with ready low for exactly 10850 cycles.
REQ-030 SHALL cover: valid held high with 0x41 then 0x7A -> two frames decoded as 0x41 and 0x7A, one idle cycle between them, with ready high for exactly one cycle.
REQ-031 SHALL cover: after accepting 0xA5, change data_in to 0xFF and toggle valid mid-frame -> line still decodes 0xA5, and no extra handshake occurs.
REQ-032 SHALL cover: reset asserted during DATA bit 3 of 0x00 -> serial_out high the next cycle, ready=1 after deassert, and next byte 0x31 framed correctly.
REQ-033 SHALL cover: idle for 20000 cycles with valid low -> serial_out constantly 1 and ready constantly 1.
REQ-034 SHALL cover: loopback into the existing uart receiver with all 256 byte values -> each received byte equals the sent byte, in order.
